// File: rtl/preamble_detector.sv
// Hard-slicing BPSK preamble correlator: counts bit matches against PREAMBLE and locks on detection.
// Optional macro PREAMBLE_INVERT_EN adds detection of the 180-degree (inverted) preamble.
module preamble_detector #(
  parameter int           PREAMBLE_LEN = 64,
  parameter logic [127:0] PREAMBLE     = 128'hA5C3_96F0_3C5A_0FF1,
  parameter int           THRESHOLD    = 60,
  localparam int          CW           = $clog2(PREAMBLE_LEN + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic signed [15:0]   in_i,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic                 rearm,
  output logic                 detect,
  output logic                 locked,
  output logic [CW-1:0]        match_count,
  output logic                 inverted
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [PREAMBLE_LEN-1:0] PAT   = PREAMBLE[PREAMBLE_LEN-1:0];
  localparam logic [CW-1:0]           LEN_C = CW'(PREAMBLE_LEN);
  localparam logic [CW-1:0]           THR_C = CW'(THRESHOLD);

  function automatic logic [CW-1:0] popcount(input logic [PREAMBLE_LEN-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < PREAMBLE_LEN; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  state_t state, state_nxt;

  // Only the newest PREAMBLE_LEN-1 bits are kept; the oldest bit would drop out of the next window.
  logic [PREAMBLE_LEN-2:0] sreg_p1;
  logic [CW-1:0]           fill_p1;

  logic                    vld_p0;
  logic                    bit_p0;
  logic [PREAMBLE_LEN-1:0] window_p0;
  logic [CW-1:0]           match_p0;
  logic                    full_p0;
  logic                    pos_hit_p0;
  logic                    neg_hit_p0;
  logic                    det_p0;
  logic                    rearm_p0;

  // ---- stage p0: slice, window, correlate ----
  assign vld_p0     = valid_in && ready_out;
  assign bit_p0     = (in_i >= 16'sd0);
  assign window_p0  = {sreg_p1, bit_p0};
  assign match_p0   = popcount(~(window_p0 ^ PAT));
  assign full_p0    = (fill_p1 >= LEN_C - CW'(1));
  assign pos_hit_p0 = full_p0 && (match_p0 >= THR_C);
`ifdef PREAMBLE_INVERT_EN
  assign neg_hit_p0 = full_p0 && (match_p0 < THR_C) && ((LEN_C - match_p0) >= THR_C);
`else
  assign neg_hit_p0 = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    det_p0    = 1'b0;
    rearm_p0  = 1'b0;
    ready_out = enable && (state != LOCKED);
    case (state)
      SEARCH: begin
        if (vld_p0 && (pos_hit_p0 || neg_hit_p0)) begin
          state_nxt = LOCKED;
          det_p0    = 1'b1;
        end
      end
      LOCKED: begin
        if (enable && rearm) begin
          state_nxt = SEARCH;
          rearm_p0  = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  // ---- stage p1: registered window, fill count and outputs ----
  always_ff @(posedge clock) begin
    if (reset) begin
      sreg_p1     <= '0;
      fill_p1     <= '0;
      match_count <= '0;
      detect      <= 1'b0;
      inverted    <= 1'b0;
    end else begin
      detect <= det_p0;
      if (vld_p0) begin
        sreg_p1     <= window_p0[PREAMBLE_LEN-2:0];
        match_count <= match_p0;
        if (fill_p1 != LEN_C) fill_p1 <= fill_p1 + CW'(1);
        if (det_p0 && !pos_hit_p0) inverted <= 1'b1;
      end
      if (rearm_p0) begin
        sreg_p1  <= '0;
        fill_p1  <= '0;
        inverted <= 1'b0;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_preamble_detector.sv
// Randomised and directed bench for preamble_detector (PREAMBLE_LEN=16, 16'hA5C3, THRESHOLD=15)
// against a queue-based behavioural model, with literal spot checks.
module tb_preamble_detector;
  localparam int          L   = 16;
  localparam int          THR = 15;
  localparam int          CW  = $clog2(L + 1);

  logic               clock    = 1'b0;
  logic               reset    = 1'b1;
  logic               enable   = 1'b0;
  logic               valid_in = 1'b0;
  logic               rearm    = 1'b0;
  logic signed [15:0] in_i     = 16'sd0;
  logic               ready_out, detect, locked, inverted;
  logic [CW-1:0]      match_count;

  logic [15:0] pat = 16'hA5C3;

  preamble_detector #(
    .PREAMBLE_LEN(L),
    .PREAMBLE(128'hA5C3),
    .THRESHOLD(THR)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .in_i(in_i), .valid_in(valid_in),
    .ready_out(ready_out), .rearm(rearm), .detect(detect), .locked(locked),
    .match_count(match_count), .inverted(inverted)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: history of accepted bits (oldest first), accepts since search began.
  bit hist[$];
  int nacc;
  bit e_locked, e_det, e_inv;
  int e_mc;

  task automatic model_clear_hist();
    hist.delete();
    for (int k = 0; k < L; k++) hist.push_back(1'b0);
    nacc = 0;
  endtask

  task automatic model_step();
    int m;
    if (reset) begin
      e_locked = 0; e_det = 0; e_mc = 0; e_inv = 0;
      model_clear_hist();
    end else if (!enable) begin
      e_det = 0;
    end else begin
      e_det = 0;
      if (e_locked) begin
        if (rearm) begin
          e_locked = 0; e_inv = 0;
          model_clear_hist();
        end
      end else if (valid_in) begin
        hist.push_back(in_i >= 0);
        void'(hist.pop_front());
        nacc++;
        m = 0;
        for (int k = 0; k < L; k++) if (hist[k] == pat[L-1-k]) m++;
        e_mc = m;
        if (nacc >= L && m >= THR) begin
          e_det = 1; e_locked = 1;
        end
`ifdef PREAMBLE_INVERT_EN
        else if (nacc >= L && (L - m) >= THR) begin
          e_det = 1; e_locked = 1; e_inv = 1;
        end
`endif
      end
    end
  endtask

  always @(posedge clock) begin
    model_step();
    #2;
    chk("detect",      32'(detect),      32'(e_det));
    chk("locked",      32'(locked),      32'(e_locked));
    chk("match_count", 32'(match_count), 32'(e_mc));
    chk("inverted",    32'(inverted),    32'(e_inv));
    chk("ready_out",   32'(ready_out),   32'(enable && !e_locked));
  end

  task automatic drive(input logic en, input logic vld, input logic signed [15:0] s,
                       input logic rr, input logic rs);
    @(negedge clock);
    enable = en; valid_in = vld; in_i = s; rearm = rr; reset = rs;
  endtask

  function automatic logic signed [15:0] smp(input logic b);
    return b ? 16'sd1000 : -16'sd1000;
  endfunction

  task automatic send_bits(input logic [15:0] p, input int first, input int last);
    for (int k = first; k <= last; k++) drive(1'b1, 1'b1, smp(p[15-k]), 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clock);
    #3;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 16'sd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
  endtask

  logic [15:0] fp;
  logic [15:0] inv_pat;

  initial begin
    inv_pat = ~pat;
    drive(1'b1, 1'b0, 16'sd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 16'sd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
    settle();
    chk("rst_detect", 32'(detect), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_mc",     32'(match_count), 0);
    chk("rst_inv",    32'(inverted), 0);
    chk("rst_ready",  32'(ready_out), 1);

    // Exact preamble
    send_bits(pat, 0, 15);
    settle();
    chk("t1_detect", 32'(detect), 1);
    chk("t1_mc",     32'(match_count), 16);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_ready",  32'(ready_out), 0);
    drive(1'b1, 1'b1, -16'sd1000, 1'b0, 1'b0);
    settle();
    chk("t1_pulse_end", 32'(detect), 0);
    chk("t1_hold_mc",   32'(match_count), 16);
    drive(1'b1, 1'b1, 16'sd1000, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'sd0, 1'b1, 1'b0);
    settle();
    chk("t1_rearm_ready",  32'(ready_out), 1);
    chk("t1_rearm_locked", 32'(locked), 0);
    chk("t1_rearm_mc",     32'(match_count), 16);
    send_bits(pat, 0, 14);
    settle();
    chk("t1_no_early", 32'(detect), 0);
    send_bits(pat, 15, 15);
    settle();
    chk("t1_second_detect", 32'(detect), 1);

    // Five random samples, then preamble with one flipped bit
    do_reset();
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0);
    fp = pat ^ 16'h0100;
    send_bits(fp, 0, 15);
    settle();
    chk("t2_detect", 32'(detect), 1);
    chk("t2_mc",     32'(match_count), 15);

    // Only the last 12 preamble bits: fill counter must block
    do_reset();
    send_bits(pat, 4, 15);
    settle();
    chk("t3_detect", 32'(detect), 0);
    chk("t3_locked", 32'(locked), 0);
    chk("t3_mc",     32'(match_count), 14);

    // Reset on the 10th preamble sample
    do_reset();
    send_bits(pat, 0, 8);
    drive(1'b1, 1'b1, smp(pat[6]), 1'b0, 1'b1);
    settle();
    chk("t4_rst_detect", 32'(detect), 0);
    chk("t4_rst_locked", 32'(locked), 0);
    chk("t4_rst_mc",     32'(match_count), 0);
    chk("t4_rst_inv",    32'(inverted), 0);
    send_bits(pat, 10, 15);
    settle();
    chk("t4_detect", 32'(detect), 0);
    chk("t4_locked", 32'(locked), 0);

    // Inverted preamble
    do_reset();
    send_bits(inv_pat, 0, 15);
    settle();
`ifdef PREAMBLE_INVERT_EN
    chk("t5_detect", 32'(detect), 1);
    chk("t5_inv",    32'(inverted), 1);
`else
    chk("t5_detect", 32'(detect), 0);
    chk("t5_inv",    32'(inverted), 0);
`endif
    chk("t5_mc", 32'(match_count), 0);

    // Enable gaps interleaved, then enable low after detection blocks rearm
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0);
      drive(1'b1, 1'b1, smp(pat[15-k]), 1'b0, 1'b0);
    end
    settle();
    chk("t6_detect", 32'(detect), 1);
    drive(1'b0, 1'b0, 16'sd0, 1'b1, 1'b0);
    settle();
    chk("t6_detect_end", 32'(detect), 0);
    chk("t6_locked",     32'(locked), 1);
    drive(1'b1, 1'b0, 16'sd0, 1'b1, 1'b0);
    settle();
    chk("t6_rearm_locked", 32'(locked), 0);

    // rearm coinciding with the detecting accept
    send_bits(pat, 0, 14);
    drive(1'b1, 1'b1, smp(pat[0]), 1'b1, 1'b0);
    settle();
    chk("t7_detect", 32'(detect), 1);
    drive(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
    settle();
    chk("t7_locked", 32'(locked), 1);
    drive(1'b1, 1'b0, 16'sd0, 1'b1, 1'b0);

    // Random traffic with embedded (possibly corrupted) preambles
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        fp = pat;
        if ($urandom_range(0, 1) == 1) fp = fp ^ (16'h1 << $urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) fp = ~fp;
        send_bits(fp, 0, 15);
      end else begin
        for (int c = 0; c < 10; c++)
          drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, 16'($urandom),
                $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
      end
    end

    drive(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/preamble_detector.md
Name: preamble_detector

Overview:
- Receive-side counterpart of the preamble generator. Accepts the signed 16-bit BPSK I-sample stream and hard-slices each sample to one bit.
- Slides the sliced bits against the stored preamble pattern and counts matching positions.
- Pulses `detect` and enters a locked state when the count reaches the threshold.
- Sits between the RX front end and the frame/symbol-timing logic of the OFDM modem.

Parameters:
- PREAMBLE_LEN, 64, number of preamble bits correlated (8..128).
- PREAMBLE, 64'hA5C3_96F0_3C5A_0FF1, reference pattern. PREAMBLE[PREAMBLE_LEN-1] is the first bit transmitted.
- THRESHOLD, 60, minimum match count for detection (1..PREAMBLE_LEN).
- CW, $clog2(PREAMBLE_LEN+1), width of match_count (derived localparam, not overridable).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  block enable. When low, samples are not accepted and state is held.
- in_i  in  16  signed BPSK I sample.
- valid_in  in  1  in_i is valid this cycle.
- ready_out  out  1  block can accept a sample. Equals enable && state!=LOCKED.
- rearm  in  1  one-cycle request to leave LOCKED and restart search.
- detect  out  1  one-cycle pulse on detection.
- locked  out  1  high while in LOCKED.
- match_count  out  CW  registered match count of the last accepted sample.
- inverted  out  1  detection was on the inverted pattern (optional feature only).

Behaviour:
- Sample accept: accept = valid_in && ready_out.
- Slicer: bit = ~in_i[15], so in_i>=0 gives 1 and in_i<0 gives 0. This matches the TX mapping of 1 to +A and 0 to -A.
- Shift register: sreg[PREAMBLE_LEN-1:0] shifts left on accept, new bit enters at bit 0. sreg[PREAMBLE_LEN-1] is the oldest bit.
- Fill counter: saturates at PREAMBLE_LEN and counts accepted samples since entering SEARCH. No detection is allowed until the counter is full, including the accept that fills it.
- Match: the next-state window is {sreg[PREAMBLE_LEN-2:0], bit}. m = popcount(~(window ^ PREAMBLE[PREAMBLE_LEN-1:0])). m is registered into match_count on every accept; match_count holds otherwise.
- Latency: detect/locked are asserted exactly 1 cycle after the accepting clock edge of the last preamble sample, aligned with the updated match_count.
- States:
  - SEARCH: on accept, if fill counter is full (including this sample) and m>=THRESHOLD, go to LOCKED and pulse detect for 1 cycle.
  - LOCKED: ready_out=0 and sreg frozen. On rearm go to SEARCH, clear sreg and the fill counter, and leave match_count unchanged.
- Reset, including mid-search or while locked:
  - state=SEARCH, sreg=0, fill=0.
  - detect=0, locked=0, match_count=0, inverted=0, ready_out=enable.
- enable low:
  - no accept and no state change.
  - a detect pulse already registered still deasserts the next cycle.
- rearm in SEARCH: ignored.
- rearm in the same cycle as a detecting accept: detection wins and state=LOCKED. rearm is only sampled in LOCKED.
- valid_in while ready_out=0: sample is dropped and not counted.

Optional Feature:
- PREAMBLE_INVERT_EN:
  - Defined: also tests for 180-degree phase ambiguity. If PREAMBLE_LEN-m >= THRESHOLD (and m<THRESHOLD), detect with inverted=1 latched until rearm/reset. match_count still reports m.
  - Not defined: inverted tied to 0 and only positive correlation is evaluated.

Test Plan:
- Params: PREAMBLE_LEN=16, PREAMBLE=16'hA5C3, THRESHOLD=16.
- Feed 16 samples of +1000/-1000 mapping 16'hA5C3 MSB-first, valid_in=1 every cycle.
  - Required: detect=1 one cycle after the 16th accept, match_count=16, locked=1, ready_out=0.
- Feed 5 random samples, then the preamble, THRESHOLD=15 with one bit flipped in the preamble.
  - Required: detect after the 21st accept, match_count=15.
- After reset, feed only the last 12 preamble bits.
  - Required: no detect even though the window partially matches; the fill counter blocks detection.
- Locked, then rearm pulse, then a second preamble.
  - Required: ready_out returns to 1 the cycle after rearm, and the second detect occurs 16 accepts later.
- Assert reset during the 10th preamble sample, then continue the remaining samples.
  - Required: no detect, and all outputs 0 the cycle after reset.
- With PREAMBLE_INVERT_EN, feed the bitwise inverse (16'h5A3C).
  - Required: detect=1, inverted=1, match_count=0. Without the macro: no detect, inverted=0.
